// File: rtl/dphy_pkt_pkg.sv
// Shared state type, header layout and CSI-2 ECC helper
// for the D-PHY packet controller.
package dphy_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DONE
  } state_e;

  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  localparam int HB_DI    = 0;
  localparam int HB_WC_LO = 1;
  localparam int HB_WC_HI = 2;
  localparam int HB_ECC   = 3;

  function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10],
             d[11], d[13], d[16], d[20], d[21], d[22], d[23]};
    p[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10],
             d[12], d[14], d[17], d[20], d[21], d[22], d[23]};
    p[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11],
             d[12], d[15], d[18], d[20], d[21], d[22]};
    p[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13],
             d[14], d[15], d[19], d[20], d[21], d[23]};
    p[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16],
             d[17], d[18], d[19], d[20], d[22], d[23]};
    p[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15],
             d[16], d[17], d[18], d[19], d[21], d[22], d[23]};
    return p;
  endfunction

endpackage

// File: rtl/dphy_pkt_ctrl_if.sv
// Lane-word input stream and payload output stream
// of the D-PHY packet controller.
interface dphy_pkt_ctrl_if #(
  parameter int DATA_LANES = 4
);
  logic [DATA_LANES*8-1:0] word_i;
  logic                    valid_i;
  logic [DATA_LANES*8-1:0] payload_o;
  logic [DATA_LANES-1:0]   payload_be_o;
  logic                    payload_valid_o;
  logic                    payload_sop_o;
  logic                    payload_eop_o;

  modport master (
    output word_i, valid_i,
    input  payload_o, payload_be_o,
    input  payload_valid_o, payload_sop_o, payload_eop_o
  );

  modport slave (
    input  word_i, valid_i,
    output payload_o, payload_be_o,
    output payload_valid_o, payload_sop_o, payload_eop_o
  );
endinterface

// File: rtl/dphy_pkt_hdr_parse.sv
// Assembles the 32-bit packet header from 1/2/4-lane words
// and checks its ECC byte.
module dphy_pkt_hdr_parse
  import dphy_pkt_pkg::*;
#(
  parameter int DATA_LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_i,
  input  logic [DATA_LANES*8-1:0] word_i,
  output logic                    last_o,
  output logic [23:0]             hdr_o,
  output logic                    ecc_err_o
);
  localparam int NW = 4 / DATA_LANES;

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] hdr_q, hdr_d, hdr_n;
  logic [5:0]  ecc_calc;

  always_comb begin
    hdr_n = hdr_q;
    for (int l = 0; l < DATA_LANES; l++)
      hdr_n[(int'(cnt_q) * DATA_LANES + l) * 8 +: 8] =
        word_i[l*8 +: 8];
    last_o = shift_i && (int'(cnt_q) == NW - 1);
    // any gap in the header stream restarts assembly
    cnt_d  = '0;
    if (shift_i && !last_o)
      cnt_d = cnt_q + 2'd1;
    hdr_d = shift_i ? hdr_n : hdr_q;
    ecc_calc  = csi2_ecc(hdr_n[23:0]);
    ecc_err_o = hdr_n[HB_ECC*8 +: 8] != {2'b00, ecc_calc};
    hdr_o     = hdr_n[23:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hdr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
    end
  end

endmodule

// File: rtl/dphy_pkt_ctrl.sv
// CSI-2 packet controller: header decode, payload/CRC
// steering and pkt_done handshake back to the aligner.
module dphy_pkt_ctrl
  import dphy_pkt_pkg::*;
#(
  parameter int          DATA_LANES = 4,
  parameter logic [15:0] MAX_WC     = 16'd8192
) (
  input  logic          byte_clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  dphy_pkt_ctrl_if.slave lane_if,
  output logic          pkt_done_o,
  output logic          hdr_valid_o,
  output logic [1:0]    vc_o,
  output logic [5:0]    dt_o,
  output logic [15:0]   wc_o,
  output logic          ecc_err_o,
  output logic          wc_err_o,
  output logic          trunc_err_o,
  output logic [15:0]   crc_o,
  output logic          crc_valid_o
);
  localparam int          W    = DATA_LANES * 8;
  localparam logic [16:0] DL17 = 17'(DATA_LANES);

  state_e state_q, state_d;
  logic skip_q, skip_d, started_q, started_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] wc_q, wc_d, crc_q, crc_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic hv_q, hv_d, ee_q, ee_d, we_q, we_d, tr_q, tr_d;
  logic pd_q, pd_d, cv_q, cv_d;
  logic pv_q, pv_d, sop_q, sop_d, eop_q, eop_d;
  logic [W-1:0] pl_q, pl_d;
  logic [DATA_LANES-1:0] be_q, be_d;

  logic start, shift, last, hdr_ecc_err;
  logic short_pkt, wc_bad;
  logic [23:0] hdr;
  logic [15:0] hdr_wc;
  logic [16:0] wc17, k;

  assign start = state_q == IDLE && !skip_q &&
                 en_i && lane_if.valid_i;
  assign shift = start ||
                 (state_q == HDR && lane_if.valid_i);

  dphy_pkt_hdr_parse #(.DATA_LANES(DATA_LANES)) u_hdr (
    .clk       (byte_clk_i),
    .rst_n     (rst_n_i),
    .shift_i   (shift),
    .word_i    (lane_if.word_i),
    .last_o    (last),
    .hdr_o     (hdr),
    .ecc_err_o (hdr_ecc_err)
  );

  always_comb begin
    state_d = state_q;  skip_d = 1'b0;
    started_d = started_q;  cnt_d = cnt_q;
    wc_d = wc_q;  vc_d = vc_q;  dt_d = dt_q;
    crc_d = crc_q;  cv_d = 1'b0;
    hv_d = 1'b0;  ee_d = 1'b0;  we_d = 1'b0;  tr_d = 1'b0;
    pl_d = '0;  be_d = '0;
    pv_d = 1'b0;  sop_d = 1'b0;  eop_d = 1'b0;
    hdr_wc = {hdr[HB_WC_HI*8 +: 8], hdr[HB_WC_LO*8 +: 8]};
    short_pkt = hdr[HB_DI*8 +: 6] <= DT_SHORT_MAX;
    wc_bad = !short_pkt && hdr_wc > MAX_WC;
    wc17 = {1'b0, wc_q};
    k = '0;
    unique case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: if (!lane_if.valid_i) begin
        tr_d = 1'b1;
        state_d = IDLE;
      end
      PAYLOAD: if (!lane_if.valid_i) begin
        tr_d = 1'b1;
        state_d = IDLE;
      end else begin
        pl_d = lane_if.word_i;
        for (int l = 0; l < DATA_LANES; l++) begin
          k = cnt_q + 17'(l);
          if (k < wc17)
            be_d[l] = 1'b1;
          else if (k == wc17)
            crc_d[7:0] = lane_if.word_i[l*8 +: 8];
          else if (k == wc17 + 17'd1)
            crc_d[15:8] = lane_if.word_i[l*8 +: 8];
        end
        pv_d  = |be_d;
        sop_d = |be_d && !started_q;
        eop_d = |be_d && (cnt_q + DL17 >= wc17);
        started_d = started_q | (|be_d);
        cnt_d = cnt_q + DL17;
        // the word holding the second CRC byte ends the packet
        if (cnt_q + DL17 >= wc17 + 17'd2) begin
          cv_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        skip_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (last) begin
      hv_d = 1'b1;
      vc_d = hdr[HB_DI*8+6 +: 2];
      dt_d = hdr[HB_DI*8 +: 6];
      wc_d = hdr_wc;
      ee_d = hdr_ecc_err;
      we_d = wc_bad;
      cnt_d = '0;
      started_d = 1'b0;
      state_d = (hdr_ecc_err || short_pkt || wc_bad) ?
                DONE : PAYLOAD;
    end
    pd_d = state_d == DONE;
  end

  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;  skip_q <= 1'b0;  started_q <= 1'b0;
      cnt_q <= '0;  wc_q <= '0;  vc_q <= '0;  dt_q <= '0;
      crc_q <= '0;  cv_q <= 1'b0;  pd_q <= 1'b0;
      hv_q <= 1'b0;  ee_q <= 1'b0;  we_q <= 1'b0;  tr_q <= 1'b0;
      pl_q <= '0;  be_q <= '0;
      pv_q <= 1'b0;  sop_q <= 1'b0;  eop_q <= 1'b0;
    end else begin
      state_q <= state_d;  skip_q <= skip_d;
      started_q <= started_d;
      cnt_q <= cnt_d;  wc_q <= wc_d;  vc_q <= vc_d;  dt_q <= dt_d;
      crc_q <= crc_d;  cv_q <= cv_d;  pd_q <= pd_d;
      hv_q <= hv_d;  ee_q <= ee_d;  we_q <= we_d;  tr_q <= tr_d;
      pl_q <= pl_d;  be_q <= be_d;
      pv_q <= pv_d;  sop_q <= sop_d;  eop_q <= eop_d;
    end
  end

  assign pkt_done_o  = pd_q;
  assign hdr_valid_o = hv_q;
  assign vc_o        = vc_q;
  assign dt_o        = dt_q;
  assign wc_o        = wc_q;
  assign ecc_err_o   = ee_q;
  assign wc_err_o    = we_q;
  assign trunc_err_o = tr_q;
  assign crc_o       = crc_q;
  assign crc_valid_o = cv_q;
  assign lane_if.payload_o       = pl_q;
  assign lane_if.payload_be_o    = be_q;
  assign lane_if.payload_valid_o = pv_q;
  assign lane_if.payload_sop_o   = sop_q;
  assign lane_if.payload_eop_o   = eop_q;

endmodule

// File: tb/tb_dphy_pkt_ctrl.sv
// Scoreboard bench for dphy_pkt_ctrl with a 4-lane and
// a 1-lane instance.
module tb_dphy_pkt_ctrl;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
    logic        sop;
    logic        eop;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  dphy_pkt_ctrl_if #(.DATA_LANES(4)) if4 ();
  dphy_pkt_ctrl_if #(.DATA_LANES(1)) if1 ();

  logic pd4, hv4, ee4, we4, tr4, cv4;
  logic [1:0] vc4;  logic [5:0] dt4;
  logic [15:0] wc4, crc4;
  logic pd1, hv1, ee1, we1, tr1, cv1;
  logic [1:0] vc1;  logic [5:0] dt1;
  logic [15:0] wc1, crc1;

  dphy_pkt_ctrl #(.DATA_LANES(4)) u4 (
    .byte_clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .lane_if(if4), .pkt_done_o(pd4), .hdr_valid_o(hv4),
    .vc_o(vc4), .dt_o(dt4), .wc_o(wc4), .ecc_err_o(ee4),
    .wc_err_o(we4), .trunc_err_o(tr4), .crc_o(crc4),
    .crc_valid_o(cv4)
  );

  dphy_pkt_ctrl #(.DATA_LANES(1)) u1 (
    .byte_clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .lane_if(if1), .pkt_done_o(pd1), .hdr_valid_o(hv1),
    .vc_o(vc1), .dt_o(dt1), .wc_o(wc1), .ecc_err_o(ee1),
    .wc_err_o(we1), .trunc_err_o(tr1), .crc_o(crc1),
    .crc_valid_o(cv1)
  );

  int total = 0;
  int bad = 0;
  pl_t plq [2][$];
  logic [25:0] hq [2][$];
  logic [15:0] cq [2][$];
  int done_n [2] = '{0, 0};
  int trunc_n [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  int exp_trunc [2] = '{0, 0};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [23:0] m [6];
    logic [5:0] r;
    m = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
          24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    for (int i = 0; i < 6; i++) r[i] = ^(d & m[i]);
    return r;
  endfunction

  task automatic mon(input int d, input logic hv,
                     input logic [25:0] h, input logic pv,
                     input pl_t p, input logic cv,
                     input logic [15:0] c, input logic pd,
                     input logic tr);
    if (hv) begin
      chk($sformatf("hdr_q%0d", d), hq[d].size() != 0, 1);
      if (hq[d].size() != 0)
        chk($sformatf("hdr%0d", d), h, hq[d].pop_front());
    end
    if (pv) begin
      chk($sformatf("pl_q%0d", d), plq[d].size() != 0, 1);
      if (plq[d].size() != 0)
        chk($sformatf("pl%0d", d), p, plq[d].pop_front());
    end
    if (cv) begin
      chk($sformatf("crc_q%0d", d), cq[d].size() != 0, 1);
      if (cq[d].size() != 0)
        chk($sformatf("crc%0d", d), c, cq[d].pop_front());
    end
    if (pd) done_n[d]++;
    if (tr) trunc_n[d]++;
  endtask

  always @(negedge clk) begin
    mon(0, hv4, {vc4, dt4, wc4, ee4, we4}, if4.payload_valid_o,
        {if4.payload_o, if4.payload_be_o,
         if4.payload_sop_o, if4.payload_eop_o},
        cv4, crc4, pd4, tr4);
    mon(1, hv1, {vc1, dt1, wc1, ee1, we1}, if1.payload_valid_o,
        {24'h0, if1.payload_o, 3'b000, if1.payload_be_o,
         if1.payload_sop_o, if1.payload_eop_o},
        cv1, crc1, pd1, tr1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic v,
                     input logic [31:0] w);
    if (d == 0) begin
      if4.valid_i = v;
      if4.word_i  = w;
    end else begin
      if1.valid_i = v;
      if1.word_i  = w[7:0];
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    if (d == 0) begin
      chk({tag, "_ctl4"}, {pd4, hv4, vc4, dt4, wc4, ee4, we4,
          tr4, cv4, if4.payload_valid_o, if4.payload_sop_o,
          if4.payload_eop_o, if4.payload_be_o}, 0);
      chk({tag, "_dat4"}, {if4.payload_o, crc4}, 0);
    end else begin
      chk({tag, "_ctl1"}, {pd1, hv1, vc1, dt1, wc1, ee1, we1,
          tr1, cv1, if1.payload_valid_o, if1.payload_sop_o,
          if1.payload_eop_o, if1.payload_be_o}, 0);
      chk({tag, "_dat1"}, {if1.payload_o, crc1}, 0);
    end
  endtask

  // mode 0: full packet; 1: valid drops at payload word cut;
  // 2: reset asserted at payload word cut
  task automatic send_pkt(input int d, input logic [7:0] di,
                          input logic [15:0] wc,
                          input logic [7:0] flip,
                          input int mode, input int cut);
    int dl, hw, nw, pw, k;
    logic [7:0] b[$];
    logic [7:0] ecc;
    logic shrt, eerr, werr, first;
    logic [31:0] w;
    pl_t e;
    dl = (d == 0) ? 4 : 1;
    hw = 4 / dl;
    ecc = {2'b00, ref_ecc({wc, di})} ^ flip;
    shrt = di[5:0] <= 6'h0F;
    eerr = flip != 0;
    werr = !shrt && wc > 16'd8192;
    b = '{di, wc[7:0], wc[15:8], ecc};
    if (!shrt && !eerr && !werr) begin
      for (int i = 0; i < int'(wc); i++) b.push_back(8'(i + 1));
      b.push_back(8'hAA);
      b.push_back(8'hBB);
    end
    while (b.size() % dl != 0) b.push_back(8'hEE);
    hq[d].push_back({di, wc, eerr, werr});
    nw = b.size() / dl;
    first = 1'b1;
    for (int wi = 0; wi < nw; wi++) begin
      pw = wi - hw;
      w = '0;
      e = '0;
      for (int l = 0; l < dl; l++) begin
        k = pw * dl + l;
        w[l*8 +: 8] = b[wi*dl + l];
        if (pw >= 0 && k < int'(wc)) e.be[l] = 1'b1;
        if (pw >= 0 && k == int'(wc) - 1) e.eop = 1'b1;
      end
      if (mode == 1 && pw == cut) begin
        drv(d, 1'b0, '0);
        step();
        chk("trunc_pulse", (d == 0) ? tr4 : tr1, 1);
        chk("trunc_nodone", (d == 0) ? pd4 : pd1, 0);
        exp_trunc[d]++;
        step();
        return;
      end
      if (mode == 2 && pw == cut) begin
        drv(d, 1'b1, w);
        rst_n = 1'b0;
        step();
        chk_zero(d, "rst_mid");
        rst_n = 1'b1;
        drv(d, 1'b0, '0);
        step();
        return;
      end
      if (pw >= 0 && int'(wc) + 1 >= pw * dl &&
          int'(wc) + 1 < pw * dl + dl)
        cq[d].push_back({8'hBB, 8'hAA});
      if (e.be != 0) begin
        e.d = w;
        e.sop = first;
        first = 1'b0;
        plq[d].push_back(e);
      end
      drv(d, 1'b1, w);
      step();
    end
    chk("done_lat", (d == 0) ? pd4 : pd1, 1);
    exp_done[d]++;
    // aligner keeps valid up for DONE and one more cycle
    drv(d, 1'b1, 32'hEEEE_EEEE);
    step();
    drv(d, 1'b1, 32'hEEEE_EEEE);
    step();
    drv(d, 1'b0, '0);
    step();
    step();
  endtask

  initial begin
    drv(0, 1'b0, '0);
    drv(1, 1'b0, '0);
    repeat (3) step();
    chk_zero(0, "rst");
    chk_zero(1, "rst");
    rst_n = 1'b1;
    step();

    send_pkt(0, 8'h2A, 16'd6, 8'h00, 0, 0);
    send_pkt(0, 8'h00, 16'h0001, 8'h00, 0, 0);
    send_pkt(0, 8'h2A, 16'd4, 8'h01, 0, 0);
    send_pkt(0, 8'h2A, 16'd7, 8'h00, 0, 0);
    send_pkt(0, 8'h6B, 16'd0, 8'h00, 0, 0);
    send_pkt(0, 8'hAA, 16'd9000, 8'h00, 0, 0);
    send_pkt(0, 8'h2A, 16'd8192, 8'h40, 0, 0);
    send_pkt(0, 8'h2A, 16'd8, 8'h00, 1, 1);
    send_pkt(1, 8'h2A, 16'd2, 8'h00, 0, 0);
    send_pkt(1, 8'h12, 16'hBEEF, 8'h00, 0, 0);
    send_pkt(1, 8'h2A, 16'd5, 8'h00, 1, 2);

    en = 1'b0;
    drv(0, 1'b1, 32'h0006_002A);
    repeat (3) step();
    drv(0, 1'b0, '0);
    step();
    en = 1'b1;
    step();

    send_pkt(0, 8'h2A, 16'd16, 8'h00, 2, 1);
    send_pkt(0, 8'h2A, 16'd3, 8'h00, 0, 0);

    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("done_cnt%0d", d), done_n[d], exp_done[d]);
      chk($sformatf("trunc_cnt%0d", d), trunc_n[d], exp_trunc[d]);
      chk($sformatf("hq_left%0d", d), hq[d].size(), 0);
      chk($sformatf("plq_left%0d", d), plq[d].size(), 0);
      chk($sformatf("cq_left%0d", d), cq[d].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
